axis_packet_fifo: RTL and testbench
===================================

AXIS_PACKET_FIFO -- requirements
Module: axis_packet_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: tdata width in bits, range 1 or more.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: entry count, range 2 or more, any integer (not limited to powers of two).
REQ-003 SHALL have parameter PACKET_MODE, default 0: 0 = cut-through, 1 = store-and-forward on tlast.
REQ-004 SHALL have parameter AFULL_THR, default FIFO_DEPTH-2: almost-full threshold, range 1 to FIFO_DEPTH.
REQ-005 SHALL have parameter AEMPTY_THR, default 2: almost-empty threshold, range 0 to FIFO_DEPTH-1.
REQ-006 SHALL have port clk_i, input, 1 bit: single clock; all state changes on its rising edge.
REQ-007 SHALL have port arst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port s_axis, axis_if.slave: fields tdata (DATA_WIDTH), tvalid (in), tlast (in), tready (out).
REQ-009 SHALL have port m_axis, axis_if.master: fields tdata (DATA_WIDTH), tvalid (out), tlast (out), tready (in).
REQ-010 SHALL have port level_o, output, $clog2(FIFO_DEPTH+1) bits: stored word count.
REQ-011 SHALL have port pkt_cnt_o, output, $clog2(FIFO_DEPTH+1) bits: stored words with tlast=1, i.e. complete packets held.
REQ-012 SHALL have port almost_full_o, output, 1 bit: level_o >= AFULL_THR.
REQ-013 SHALL have port almost_empty_o, output, 1 bit: level_o <= AEMPTY_THR.

Function
REQ-014 Storage SHALL be FIFO_DEPTH entries of {tlast, tdata}; rd/wr pointers wrap from FIFO_DEPTH-1 to 0.
REQ-015 push = s_axis.tvalid & s_axis.tready; pop = m_axis.tvalid & m_axis.tready.
REQ-016 s_axis.tready SHALL be 1 iff level_o != FIFO_DEPTH, registered-state based with no combinational path from m_axis.tready.
REQ-017 m_axis.tdata/tlast SHALL be driven combinationally from the entry at rd pointer (show-ahead).
REQ-018 Write-to-read latency SHALL be 1 cycle: a word pushed at edge N is visible on m_axis from after edge N.
REQ-019 PACKET_MODE=0: m_axis.tvalid SHALL equal (level_o != 0).
REQ-020 PACKET_MODE=1: m_axis.tvalid SHALL equal (level_o != 0) & ((pkt_cnt_o != 0) | (level_o == FIFO_DEPTH)); the full-without-tlast case forces cut-through to avoid deadlock.
REQ-021 level_o update: push only gives +1; pop only gives -1; both or neither leaves it unchanged.
REQ-022 pkt_cnt_o update: +1 on push with s_axis.tlast=1, -1 on pop with m_axis.tlast=1; both in the same cycle leaves it unchanged.
REQ-023 Simultaneous push and pop when level_o=0 is impossible, since tvalid=0.
REQ-024 When full, a pop SHALL free one slot, with tready rising the next cycle.
REQ-025 Once m_axis.tvalid is asserted, it SHALL stay high and tdata/tlast SHALL stay stable until pop, per AXIS rules.
REQ-026 almost_full_o and almost_empty_o SHALL be combinational decodes of registered level_o.
REQ-027 Counters SHALL never overflow or underflow; the handshake rules guarantee this, and a verification assertion SHALL check it.

Reset
REQ-028 While arst_i=1, asynchronously: pointers, level_o and pkt_cnt_o SHALL be 0.
REQ-029 While arst_i=1: m_axis.tvalid=0, s_axis.tready=0, almost_empty_o=1, almost_full_o=0.
REQ-030 Storage contents SHALL NOT be reset; m_axis.tdata is don't-care while tvalid=0.
REQ-031 s_axis.tready SHALL rise on the first clk_i edge after arst_i deasserts.
REQ-032 Reset mid-packet SHALL discard all contents, including partial packets.

Verification
REQ-033 Default params, PACKET_MODE=0: push 0x0001..0x0010 with m_axis.tready=0 -> tready=0 after 16th word, level_o=16, almost_full_o=1 from level 14. Then drain -> data 0x0001..0x0010 in order, level_o returns to 0, almost_empty_o=1 at level 2.
REQ-034 Continuous push+pop with both ready=1 for 100 cycles -> level_o stays at 1 after fill, throughput 1 word/cycle, no loss across pointer wrap.
REQ-035 PACKET_MODE=1: push 3 words, last with tlast=1, one per cycle -> m_axis.tvalid stays 0 until the cycle after the 3rd push, pkt_cnt_o=1. Drain -> pkt_cnt_o=0.
REQ-036 PACKET_MODE=1, FIFO_DEPTH=4: push 4 words with tlast=0 -> m_axis.tvalid=1 once level_o=4 (forced release), data 0..3 out in order.
REQ-037 FIFO_DEPTH=5 (non-power-of-2): 12 words through with random valid/ready -> in-order data, wrap at pointer 4, level_o never exceeds 5.
REQ-038 Assert arst_i for 1 cycle with level_o=3 mid-packet -> outputs as REQ-028/029 immediately, then a new packet passes correctly.

Source files
------------

// File: rtl/axis_packet_fifo_if.sv
// AXI4-Stream bundle shared by both sides of the packet FIFO.
// Only tdata, tvalid, tlast and tready are carried.
interface axis_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_packet_fifo.sv
// Single-clock AXI4-Stream FIFO with show-ahead output and optional store-and-forward
// release on tlast; level, packet count and almost-full/empty flags are exported.
module axis_packet_fifo #(
    parameter int DATA_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 16,
    parameter int PACKET_MODE = 0,
    parameter int AFULL_THR   = FIFO_DEPTH - 2,
    parameter int AEMPTY_THR  = 2
) (
    input  logic                               clk_i,
    input  logic                               arst_i,
    axis_if.slave                              s_axis,
    axis_if.master                             m_axis,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    level_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    pkt_cnt_o,
    output logic                               almost_full_o,
    output logic                               almost_empty_o
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic                in_ready;
    logic                push;
    logic                pop;
    logic                pkt_push;
    logic                pkt_pop;
    logic                full;
    logic                release_ok;
    logic [CW-1:0]       level_nxt;
    logic [CW-1:0]       pkt_nxt;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full     = (level_o == CW'(FIFO_DEPTH));
    assign push     = s_axis.tvalid & in_ready;
    assign pop      = m_axis.tvalid & m_axis.tready;
    assign pkt_push = push & s_axis.tlast;
    assign pkt_pop  = pop & m_axis.tlast;

    // A full FIFO with no tlast inside can never complete a packet, so it is released anyway.
    assign release_ok = (PACKET_MODE == 0) || (pkt_cnt_o != '0) || full;

    assign s_axis.tready                 = in_ready;
    assign m_axis.tvalid                 = (level_o != '0) & release_ok;
    assign {m_axis.tlast, m_axis.tdata}  = mem[rd_ptr];

    assign almost_full_o  = (level_o >= CW'(AFULL_THR));
    assign almost_empty_o = (level_o <= CW'(AEMPTY_THR));

    always_comb begin
        level_nxt = level_o;
        if (push && !pop) begin
            level_nxt = level_o + CW'(1);
        end else if (pop && !push) begin
            level_nxt = level_o - CW'(1);
        end
    end

    always_comb begin
        pkt_nxt = pkt_cnt_o;
        if (pkt_push && !pkt_pop) begin
            pkt_nxt = pkt_cnt_o + CW'(1);
        end else if (pkt_pop && !pkt_push) begin
            pkt_nxt = pkt_cnt_o - CW'(1);
        end
    end

    // tready is a flop of the next level so it stays low through reset and has no path from m_axis.tready.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level_o   <= '0;
            pkt_cnt_o <= '0;
            in_ready  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            level_o   <= level_nxt;
            pkt_cnt_o <= pkt_nxt;
            in_ready  <= (level_nxt != CW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {s_axis.tlast, s_axis.tdata};
        end
    end

`ifndef SYNTHESIS
    a_counter_bounds: assert property (@(posedge clk_i) disable iff (arst_i)
        !(push && !pop && full) &&
        !(pop && level_o == '0) &&
        !(pkt_pop && !pkt_push && pkt_cnt_o == '0) &&
        !(pkt_push && !pkt_pop && pkt_cnt_o == CW'(FIFO_DEPTH)) &&
        (pkt_cnt_o <= level_o));
`endif

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Directed bench for axis_packet_fifo: cut-through depth 16, store-and-forward depth 4,
// and cut-through depth 5 with random handshakes against a small level model.
module tb_axis_packet_fifo;
    logic clk;
    logic arst;

    axis_if #(.DATA_WIDTH(16)) s0 ();
    axis_if #(.DATA_WIDTH(16)) m0 ();
    axis_if #(.DATA_WIDTH(16)) s1 ();
    axis_if #(.DATA_WIDTH(16)) m1 ();
    axis_if #(.DATA_WIDTH(16)) s2 ();
    axis_if #(.DATA_WIDTH(16)) m2 ();

    logic [4:0] level0, pkt0;
    logic [2:0] level1, pkt1, level2, pkt2;
    logic       af0, ae0, af1, ae1, af2, ae2;

    int total = 0;
    int bad   = 0;

    axis_packet_fifo #(.DATA_WIDTH(16), .FIFO_DEPTH(16), .PACKET_MODE(0)) dut0 (
        .clk_i(clk), .arst_i(arst), .s_axis(s0), .m_axis(m0),
        .level_o(level0), .pkt_cnt_o(pkt0), .almost_full_o(af0), .almost_empty_o(ae0));

    axis_packet_fifo #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .PACKET_MODE(1)) dut1 (
        .clk_i(clk), .arst_i(arst), .s_axis(s1), .m_axis(m1),
        .level_o(level1), .pkt_cnt_o(pkt1), .almost_full_o(af1), .almost_empty_o(ae1));

    axis_packet_fifo #(.DATA_WIDTH(16), .FIFO_DEPTH(5), .PACKET_MODE(0)) dut2 (
        .clk_i(clk), .arst_i(arst), .s_axis(s2), .m_axis(m2),
        .level_o(level2), .pkt_cnt_o(pkt2), .almost_full_o(af2), .almost_empty_o(ae2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_out;
        int nxt_in;
        int in_cnt, out_cnt, lvl, cyc;
        bit p_in, p_out;

        arst = 1'b1;
        s0.tvalid = 0; s0.tdata = '0; s0.tlast = 0; m0.tready = 0;
        s1.tvalid = 0; s1.tdata = '0; s1.tlast = 0; m1.tready = 0;
        s2.tvalid = 0; s2.tdata = '0; s2.tlast = 0; m2.tready = 0;
        step();
        step();

        // Reset state
        chk("rst_tready", s0.tready, 0);
        chk("rst_tvalid", m0.tvalid, 0);
        chk("rst_level", level0, 0);
        chk("rst_pkt", pkt0, 0);
        chk("rst_ae", ae0, 1);
        chk("rst_af", af0, 0);
        arst = 1'b0;
        #1;
        chk("rst_tready_hold", s0.tready, 0);
        step();
        chk("rst_tready_rise", s0.tready, 1);

        // Fill depth-16 cut-through FIFO with no reader
        for (int i = 1; i <= 16; i++) begin
            s0.tvalid = 1; s0.tdata = 16'(i); s0.tlast = 0;
            step();
            chk("fill_level", level0, i);
            chk("fill_af", af0, (i >= 14) ? 1 : 0);
        end
        s0.tvalid = 0;
        chk("full_tready", s0.tready, 0);
        chk("full_tvalid", m0.tvalid, 1);

        // Drain in order
        m0.tready = 1;
        for (int i = 1; i <= 16; i++) begin
            chk("drain_valid", m0.tvalid, 1);
            chk("drain_data", m0.tdata, i);
            step();
            chk("drain_level", level0, 16 - i);
            chk("drain_ae", ae0, (16 - i <= 2) ? 1 : 0);
            if (i == 1) chk("unfull_tready", s0.tready, 1);
        end
        chk("empty_tvalid", m0.tvalid, 0);

        // Continuous streaming across many pointer wraps
        s0.tvalid = 1; s0.tlast = 0;
        nxt_in = 16'h0100; exp_out = 16'h0100;
        for (int c = 0; c < 100; c++) begin
            s0.tdata = 16'(nxt_in);
            if (m0.tvalid) begin
                chk("thru_data", m0.tdata, exp_out);
                exp_out++;
            end
            step();
            nxt_in++;
            chk("thru_level", level0, 1);
        end
        s0.tvalid = 0;
        chk("thru_last", m0.tdata, exp_out);
        exp_out++;
        step();
        chk("thru_final_level", level0, 0);
        chk("thru_count", exp_out, 16'h0164);
        m0.tready = 0;

        // Store-and-forward: 3-word packet held until tlast arrives
        for (int i = 0; i < 3; i++) begin
            s1.tvalid = 1; s1.tdata = 16'h0A0 + 16'(i); s1.tlast = (i == 2);
            step();
            chk("sf_tvalid", m1.tvalid, (i == 2) ? 1 : 0);
        end
        s1.tvalid = 0; s1.tlast = 0;
        chk("sf_pkt", pkt1, 1);
        chk("sf_level", level1, 3);
        m1.tready = 1;
        for (int i = 0; i < 3; i++) begin
            chk("sf_data", m1.tdata, 16'h0A0 + i);
            chk("sf_tlast", m1.tlast, (i == 2) ? 1 : 0);
            step();
        end
        chk("sf_pkt_drained", pkt1, 0);
        chk("sf_level_drained", level1, 0);
        m1.tready = 0;

        // Store-and-forward forced release when full without tlast
        for (int i = 0; i < 4; i++) begin
            s1.tvalid = 1; s1.tdata = 16'(i); s1.tlast = 0;
            step();
            chk("force_tvalid", m1.tvalid, (i == 3) ? 1 : 0);
        end
        s1.tvalid = 0;
        chk("force_level", level1, 4);
        chk("force_tready", s1.tready, 0);
        chk("force_data0", m1.tdata, 0);
        m1.tready = 1;
        step();
        chk("force_level_after", level1, 3);
        chk("force_tvalid_drop", m1.tvalid, 0);
        s1.tvalid = 1; s1.tdata = 16'd4; s1.tlast = 1;
        step();
        s1.tvalid = 0; s1.tlast = 0;
        chk("force_pkt", pkt1, 1);
        for (int i = 1; i <= 4; i++) begin
            chk("force_valid", m1.tvalid, 1);
            chk("force_data", m1.tdata, i);
            chk("force_tlast", m1.tlast, (i == 4) ? 1 : 0);
            step();
        end
        chk("force_empty", level1, 0);
        m1.tready = 0;

        // Reset in the middle of a packet
        for (int i = 0; i < 3; i++) begin
            s1.tvalid = 1; s1.tdata = 16'h0E0 + 16'(i); s1.tlast = 0;
            step();
        end
        s1.tvalid = 0;
        chk("mid_level", level1, 3);
        arst = 1'b1;
        #1;
        chk("mid_rst_level", level1, 0);
        chk("mid_rst_pkt", pkt1, 0);
        chk("mid_rst_tready", s1.tready, 0);
        chk("mid_rst_tvalid", m1.tvalid, 0);
        chk("mid_rst_ae", ae1, 1);
        chk("mid_rst_af", af1, 0);
        step();
        arst = 1'b0;
        step();
        chk("mid_tready_rise", s1.tready, 1);
        s1.tvalid = 1; s1.tdata = 16'h0B0; s1.tlast = 0;
        step();
        chk("mid_new_hold", m1.tvalid, 0);
        s1.tdata = 16'h0B1; s1.tlast = 1;
        step();
        s1.tvalid = 0; s1.tlast = 0;
        chk("mid_new_level", level1, 2);
        m1.tready = 1;
        chk("mid_new_d0", m1.tdata, 16'h0B0);
        step();
        chk("mid_new_d1", m1.tdata, 16'h0B1);
        chk("mid_new_tlast", m1.tlast, 1);
        step();
        chk("mid_new_empty", level1, 0);
        m1.tready = 0;

        // Depth-5 FIFO with random handshakes
        in_cnt = 0; out_cnt = 0; lvl = 0; cyc = 0;
        while (out_cnt < 12 && cyc < 400) begin
            s2.tvalid = (in_cnt < 12) && ($urandom_range(0, 1) == 1);
            s2.tdata  = 16'h0200 + 16'(in_cnt);
            s2.tlast  = (in_cnt == 11);
            m2.tready = ($urandom_range(0, 1) == 1);
            p_in  = s2.tvalid && s2.tready;
            p_out = m2.tvalid && m2.tready;
            if (p_out) begin
                chk("rnd_data", m2.tdata, 16'h0200 + out_cnt);
                out_cnt++;
            end
            if (p_in) in_cnt++;
            lvl = lvl + int'(p_in) - int'(p_out);
            step();
            chk("rnd_level", level2, lvl);
            chk("rnd_max", (level2 <= 5) ? 1 : 0, 1);
            cyc++;
        end
        s2.tvalid = 0; m2.tready = 0;
        chk("rnd_done", out_cnt, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
